// File: rtl/weight_loader_if.sv
// Handshake bundle for the weight loader: command, ROM read port and
// output row stream. The loader side uses the master modport.
interface weight_loader_if #(
  parameter int ADDR_W = 12
);
  // command
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_rows;
  logic              busy;
  logic              done;
  logic              err;
  // ROM read port
  logic              rom_read_enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data0;
  logic [31:0]       rom_data1;
  logic [31:0]       rom_data2;
  logic [31:0]       rom_data3;
  // output row stream
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data0;
  logic [31:0]       out_data1;
  logic [31:0]       out_data2;
  logic [31:0]       out_data3;
  logic              out_last;

  modport master (
    input  start, base_addr, num_rows,
    output busy, done, err,
    output rom_read_enable, rom_addr,
    input  rom_data0, rom_data1, rom_data2, rom_data3,
    output out_valid, out_data0, out_data1, out_data2, out_data3, out_last,
    input  out_ready
  );

  modport slave (
    output start, base_addr, num_rows,
    input  busy, done, err,
    input  rom_read_enable, rom_addr,
    output rom_data0, rom_data1, rom_data2, rom_data3,
    input  out_valid, out_data0, out_data1, out_data2, out_data3, out_last,
    output out_ready
  );
endinterface

// File: rtl/weight_loader.sv
// Weight ROM read sequencer. Streams num_rows consecutive 128-bit rows from
// base_addr to a valid/ready consumer. The ROM's one-cycle latency is hidden
// by presenting returning ROM data directly when the 2-entry buffer is empty,
// and parking it in the buffer when the consumer stalls.
module weight_loader #(
  parameter int DEPTH  = 2696,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  weight_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  // lane 3 holds rom_data0 (row bits [127:96]), lane 0 holds rom_data3
  typedef struct packed {
    logic             last;
    logic [3:0][31:0] data;
  } entry_t;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_R   = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              inflight_last;
  logic              busy_q, done_q, err_q;

  entry_t            buf_q [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  entry_t            rom_entry;
  entry_t            head;
  logic [ADDR_W+1:0] sum;
  logic [2:0]        occ;
  logic              out_valid, pop, pop_buf, push, issue, last_pop;

  // Datapath decode: head selection, handshake and issue decision
  always_comb begin
    rom_entry.last = inflight_last;
    rom_entry.data = {bus.rom_data0, bus.rom_data1, bus.rom_data2, bus.rom_data3};
    head = '0;
    if (count != 2'd0)
      head = buf_q[rd_ptr];
    else if (inflight)
      head = rom_entry;
    out_valid = (count != 2'd0) || inflight;
    pop       = out_valid && bus.out_ready;
    pop_buf   = pop && (count != 2'd0);
    // returning row skips the buffer when it is consumed on arrival
    push      = inflight && !(pop && (count == 2'd0));
    occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == FETCH) && (remaining != '0) && (occ <= 3'd1);
    last_pop  = pop && head.last;
    sum       = {2'b00, bus.base_addr} + {1'b0, bus.num_rows};
  end

  assign bus.rom_read_enable = issue;
  assign bus.rom_addr        = issue ? next_addr : addr_q;
  assign bus.out_valid       = out_valid;
  assign bus.out_data0       = head.data[3];
  assign bus.out_data1       = head.data[2];
  assign bus.out_data2       = head.data[1];
  assign bus.out_data3       = head.data[0];
  assign bus.out_last        = head.last;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;

  // Command FSM: bounds check, address/row counters, status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      next_addr <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (sum > DEPTH_W) begin
              err_q <= 1'b1;
            end else if (bus.num_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              next_addr <= bus.base_addr;
              remaining <= bus.num_rows;
              busy_q    <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            next_addr <= next_addr + ADDR_W'(1);
            remaining <= remaining - ONE_R;
            if (remaining == ONE_R)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tracking: one read in flight, tagged if it is the final row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == ONE_R);
      if (issue)
        addr_q <= next_addr;
    end
  end

  // Two-entry row buffer absorbing the ROM latency under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++)
        buf_q[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= rom_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_buf)
        rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop_buf);
    end
  end

`ifndef SYNTHESIS
  // The issue rule keeps a push away from a full buffer
  always @(posedge clk)
    if (!reset)
      assert (!(push && count == 2'd2));
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: commands push expected reads and rows
// into queues, a negedge monitor pops and compares whatever the DUT presents.
module tb_weight_loader;
  localparam int DEPTH = 2696;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  weight_loader_if #(.ADDR_W(AW)) bus();

  weight_loader #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {int addr; bit last;} exp_t;

  exp_t exp_rows[$];
  int   exp_rd[$];
  int   nchecks = 0, nerr = 0;
  int   exp_done = 0, exp_err = 0, done_cnt = 0, err_cnt = 0, pop_cnt = 0;
  int   cyc = 0, t0 = 0, mode = 0;

  // Reference ROM contents: each lane a distinct scramble of the address
  function automatic logic [127:0] rom_row(input int a);
    logic [31:0] x;
    x = a * 32'h9E3779B1;
    return {x ^ 32'h1111_1111, x ^ 32'h2222_2222, x ^ 32'h4444_4444, x ^ 32'h8888_8888};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ROM: data valid the cycle after a strobe, zeros otherwise
  logic [127:0] rom_q = '0;
  always @(posedge clk) rom_q <= bus.rom_read_enable ? rom_row(int'(bus.rom_addr)) : '0;
  assign bus.rom_data0 = rom_q[127:96];
  assign bus.rom_data1 = rom_q[95:64];
  assign bus.rom_data2 = rom_q[63:32];
  assign bus.rom_data3 = rom_q[31:0];

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness: 0 always ready, 1 pattern 1,0,0, 2 random
  int ph = 0;
  initial bus.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (ph % 3 == 0);
      default: bus.out_ready = 1'($urandom_range(1, 0));
    endcase
    ph++;
  end

  // Monitor: read addresses, accepted rows, stall stability, pulses
  logic         stalled = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;
  always @(negedge clk) begin
    logic [127:0] d;
    d = {bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3};
    if (!reset) begin
      if (bus.rom_read_enable) begin
        if (exp_rd.size() == 0) chk("unexpected_read", {116'd0, bus.rom_addr}, '1);
        else chk("read_addr", {116'd0, bus.rom_addr}, 128'(exp_rd.pop_front()));
      end
      if (stalled) begin
        chk("stall_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("stall_data", d, prev_data);
        chk("stall_last", {127'd0, bus.out_last}, {127'd0, prev_last});
      end
      if (bus.out_valid && bus.out_ready) begin
        pop_cnt++;
        if (exp_rows.size() == 0) chk("unexpected_row", d, '1);
        else begin
          exp_t e;
          e = exp_rows.pop_front();
          chk("row_data", d, rom_row(e.addr));
          chk("row_last", {127'd0, bus.out_last}, {127'd0, e.last});
        end
      end
      stalled   = bus.out_valid && !bus.out_ready;
      prev_data = d;
      prev_last = bus.out_last;
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
    end else stalled = 1'b0;
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  // Issue a command from IDLE and record what the spec says must follow
  task automatic issue(input int b, input int n);
    tick();
    bus.start = 1'b1; bus.base_addr = AW'(b); bus.num_rows = (AW+1)'(n);
    t0 = cyc;
    if (b + n > DEPTH) exp_err++;
    else begin
      exp_done++;
      for (int i = 0; i < n; i++) begin
        exp_rows.push_back('{addr: b + i, last: (i == n - 1)});
        exp_rd.push_back(b + i);
      end
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 2000; k++) begin
      if (!bus.busy && exp_rows.size() == 0) break;
      tick();
    end
    if (k == 2000) chk("idle_timeout", 128'd0, 128'd1);
    tick(); tick();
    chk("done_count", 128'(done_cnt), 128'(exp_done));
    chk("err_count", 128'(err_cnt), 128'(exp_err));
    chk("reads_left", 128'(exp_rd.size()), 128'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {127'd0, bus.busy}, 128'd0);
    chk({tag, "_done"}, {127'd0, bus.done}, 128'd0);
    chk({tag, "_err"}, {127'd0, bus.err}, 128'd0);
    chk({tag, "_rre"}, {127'd0, bus.rom_read_enable}, 128'd0);
    chk({tag, "_addr"}, {116'd0, bus.rom_addr}, 128'd0);
    chk({tag, "_valid"}, {127'd0, bus.out_valid}, 128'd0);
    chk({tag, "_data"}, {bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3}, 128'd0);
    chk({tag, "_last"}, {127'd0, bus.out_last}, 128'd0);
  endtask

  initial begin
    int k, p0;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // continuous stream: timing of busy, first read, first beat and done
    mode = 0; tick();
    issue(10, 4);
    chk("cont_busy", {127'd0, bus.busy}, 128'd1);
    chk("cont_first_rre", {127'd0, bus.rom_read_enable}, 128'd1);
    tick();
    chk("cont_first_valid", {127'd0, bus.out_valid}, 128'd1);
    for (k = 0; k < 20 && !bus.done; k++) tick();
    chk("cont_done_latency", 128'(cyc - t0), 128'd6);
    wait_idle();

    // backpressure pattern 1,0,0
    mode = 1; issue(300, 6); wait_idle();

    // bounds: last legal row, then one past the end
    mode = 0; issue(2690, 6); wait_idle();
    issue(2690, 7);
    chk("oob_err", {127'd0, bus.err}, 128'd1);
    chk("oob_busy", {127'd0, bus.busy}, 128'd0);
    chk("oob_rre", {127'd0, bus.rom_read_enable}, 128'd0);
    wait_idle();

    // zero rows
    issue(50, 0);
    chk("zero_done", {127'd0, bus.done}, 128'd1);
    chk("zero_busy", {127'd0, bus.busy}, 128'd0);
    wait_idle();

    // reset abort after two accepted rows
    p0 = pop_cnt;
    issue(512, 8);
    for (k = 0; k < 50 && pop_cnt < p0 + 2; k++) @(negedge clk);
    if (k == 50) chk("abort_timeout", 128'd0, 128'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("abort");
    exp_rows.delete(); exp_rd.delete(); exp_done--;
    reset = 1'b0;
    chk("abort_stale_rom", {127'd0, bus.out_valid}, 128'd0);
    tick();
    issue(0, 2); wait_idle();

    // start while busy is ignored
    mode = 1; issue(100, 5);
    tick();
    chk("ignored_busy", {127'd0, bus.busy}, 128'd1);
    bus.start = 1'b1; bus.base_addr = AW'(7); bus.num_rows = (AW+1)'(3);
    tick();
    bus.start = 1'b0;
    wait_idle();
    repeat (10) tick();
    chk("ignored_done_count", 128'(done_cnt), 128'(exp_done));

    // randomized commands and readiness
    for (int i = 0; i < 14; i++) begin
      int b, n;
      mode = int'($urandom_range(2, 0));
      n = int'($urandom_range(12, 0));
      b = (i % 4 == 3) ? DEPTH - int'($urandom_range(8, 0)) : int'($urandom_range(DEPTH - 1, 0));
      if (b >= DEPTH) b = DEPTH - 1;
      issue(b, n);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

Read-side sequencer for the weight ROM. On a start command it streams `num_rows` consecutive 128-bit ROM rows, one row per four-channel kernel row, from `base_addr` to the systolic-array weight registers over a valid/ready handshake. It absorbs the ROM's one-cycle read latency with a 2-entry buffer, so it sustains one row per cycle under no backpressure and loses no data when stalled.

## Interface
- `DEPTH`, default 2696: ROM depth in rows. Must match the weight ROM instance.
- `ADDR_W`, default `$clog2(DEPTH)`: ROM address width.
- `clk` input, 1 bit: clock. All logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: command strobe. Sampled only in IDLE.
- `base_addr` input, `ADDR_W` bits: first ROM row. Sampled with `start`.
- `num_rows` input, `ADDR_W+1` bits: number of rows to stream (0..DEPTH). Sampled with `start`.
- `busy` output, 1 bit: a command is in progress.
- `done` output, 1 bit: one-cycle pulse when a command completes.
- `err` output, 1 bit: one-cycle pulse when a command is rejected for being out of bounds.
- `rom_read_enable` output, 1 bit: ROM read strobe.
- `rom_addr` output, `ADDR_W` bits: ROM address.
- `rom_data0`..`rom_data3` inputs, 32 bits each: ROM outputs, valid the cycle after a strobe. `data0` is row bits [127:96]; `data3` is row bits [31:0].
- `out_valid` output, 1 bit: an output row is available.
- `out_ready` input, 1 bit: the consumer accepts the row.
- `out_data0`..`out_data3` outputs, 32 bits each: row lanes. Lane order is passed through unchanged from the ROM.
- `out_last` output, 1 bit: marks the final row of the command. Qualified by `out_valid`.

## Operation
- States are IDLE, FETCH and DRAIN.
- **IDLE, `start`=1:**
  - Compute `base_addr + num_rows` at `ADDR_W+2` bits.
  - If the sum is greater than DEPTH: pulse `err` the next cycle, stay in IDLE, issue no reads, and do not assert `done`.
  - Else if `num_rows`=0: pulse `done` the next cycle and stay in IDLE.
  - Otherwise: latch `next_addr`=`base_addr` and `remaining`=`num_rows`, set `busy`, and go to FETCH.
- **`start` while not in IDLE:** ignored.
- **Issue rule (FETCH):**
  - `pop` = `out_valid && out_ready`.
  - Issue when `remaining`>0 and `count + inflight - pop <= 1`.
    - `count` is the buffer occupancy, 0..2.
    - `inflight` is 1 if a read was issued in the previous cycle.
  - On issue, `rom_read_enable`=1 and `rom_addr`=`next_addr`. Then increment `next_addr` and decrement `remaining`.
- **Non-issue cycles:** `rom_read_enable`=0 and `rom_addr` holds its last value.
- **Capture:** the cycle after an issue, push `rom_data0..3` into the buffer. Tag the entry `last` if it belongs to the final issued row. Never capture ROM data when `inflight`=0, because the ROM drives zeros then.
- **Output:** `out_*` present the buffer head. Data and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- **FETCH → DRAIN:** when `remaining` reaches 0.
- **DRAIN → IDLE:** on the handshake of the `last` row. `busy` falls and `done` pulses in the following cycle.
- **Simultaneous push and pop** with `count`=2 cannot occur, because the issue rule prevents it. An overflow is a design error and fires a simulation assertion.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `rom_read_enable`=0, `rom_addr`=0, `out_valid`=0, `out_data0..3`=0, `out_last`=0. The buffer, `count`, `inflight` and `remaining` are cleared.
- **Reset mid-command:** aborts immediately with no `done`. ROM data returning after reset is ignored.
- **Start latency:** `start` at cycle T gives `busy`=1 at T+1 and the first `rom_read_enable` at T+1. The first `out_valid` is at T+2.
- **Throughput:** with `out_ready` held high, one row per cycle. N rows have `out_valid` in cycles T+2..T+N+1, and `done` pulses at T+N+2.
- **Backpressure:** with `out_ready` low, at most 2 rows are buffered and reads stop. Reads resume in the same cycle the pop frees space, per the issue rule.
- **Back-to-back commands:** a new `start` is accepted in the cycle `done` is high, because the block is already in IDLE.

## Test plan
- **Continuous stream:** `base_addr`=10, `num_rows`=4, `out_ready`=1 → reads 10..13 on consecutive cycles. Four consecutive output beats match ROM rows 10..13, `out_last` is set on beat 4, and `done` pulses 6 cycles after `start`.
- **Backpressure:** `num_rows`=6, `out_ready` toggling 1,0,0,1,... → rows arrive in order with no loss and no duplication. Data stays stable while stalled, and there is no buffer overflow.
- **Bounds:** `base_addr`=2690, `num_rows`=6 is accepted and its last read is at address 2695. `base_addr`=2690, `num_rows`=7 → `err` pulses, no `rom_read_enable`, and `busy` stays 0.
- **Zero rows:** `num_rows`=0 → `done` pulse at T+1, with no reads and no `out_valid`.
- **Reset abort:** assert `reset` after 2 of 8 rows → all outputs return to reset values immediately. A subsequent command with `base_addr`=0, `num_rows`=2 streams correctly.
- **Ignored start:** pulse `start` with different arguments while `busy` → the original command completes unaffected and no second `done` follows.
